pack_gather: RTL and testbench



---
 rtl/pack_gather_pkg.sv | 21 ++
 rtl/pack_gather_shift.sv | 29 ++
 rtl/pack_gather.sv | 139 +++++++++++++
 tb/tb_pack_gather.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pack_gather_pkg.sv
// Shared types and helpers for the pack_gather block (sized for the default configuration).
package pack_gather_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 32;

    typedef logic [$clog2(N_DEF):0]   cnt_t;
    typedef logic [$clog2(2*N_DEF):0] tot_t;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/pack_gather_shift.sv
// Concatenates the staged words with the valid input lanes, input appended at lane stage_cnt.
module pack_gather_shift #(
    parameter int N  = 8,
    parameter int W  = 32,
    parameter int CW = $clog2(N) + 1
) (
    input  logic [N-2:0][W-1:0]   stage_w,
    input  logic [CW-1:0]         stage_cnt,
    input  logic [N-1:0][W-1:0]   in_w,
    input  logic [CW-1:0]         k,
    output logic [2*N-2:0][W-1:0] comb_w
);

    always_comb begin
        comb_w = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (i < int'(stage_cnt)) begin
                comb_w[i] = stage_w[i];
            end
        end
        // stage_cnt <= N-1 and j <= N-1, so the target lane never exceeds 2N-2
        for (int j = 0; j < N; j++) begin
            if (j < int'(k)) begin
                comb_w[int'(stage_cnt) + j] = in_w[j];
            end
        end
    end

endmodule

// File: rtl/pack_gather.sv
// Gathers partial packed vectors into full N-word beats; a pass marker flushes the residue.
module pack_gather
    import pack_gather_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic                  in_pass,
    input  logic [N-1:0][W-1:0]   in_w,
    input  logic [N-1:0]          in_vld_w,
    output logic                  out_vld_r,
    input  logic                  out_rdy,
    output logic [N-1:0][W-1:0]   out_r,
    output logic [N-1:0]          out_msk_r,
    output logic [$clog2(N):0]    out_cnt_r,
    output logic                  out_last_r
);

    localparam int CW = $clog2(N) + 1;
    localparam int TW = $clog2(2*N) + 1;

    // Handshake: a beat transfers on a rising clk edge where out_vld_r & out_rdy;
    // an input vector transfers where in_vld & in_rdy. Neither ready depends on its valid.

    state_t                 state, state_nx;
    logic [CW-1:0]          stage_cnt, stage_cnt_nx;
    logic [N-2:0][W-1:0]    stage_w, stage_w_nx;
    logic [2*N-2:0][W-1:0]  comb_w;
    logic [CW-1:0]          k;
    logic [TW-1:0]          total;
    logic                   out_free, accept;
    logic                   load, beat_last;
    logic [N-1:0][W-1:0]    beat_w;
    logic [CW-1:0]          beat_cnt;

    assign out_free = ~out_vld_r | out_rdy;
    assign in_rdy   = out_free & (state == ST_RUN);
    assign accept   = in_vld & in_rdy;
    assign k        = CW'(popcount(64'(in_vld_w)));
    assign total    = TW'(stage_cnt) + TW'(k);

    pack_gather_shift #(.N(N), .W(W), .CW(CW)) u_shift (
        .stage_w   (stage_w),
        .stage_cnt (stage_cnt),
        .in_w      (in_w),
        .k         (k),
        .comb_w    (comb_w)
    );

    always_comb begin
        state_nx     = state;
        stage_cnt_nx = stage_cnt;
        stage_w_nx   = stage_w;
        load         = 1'b0;
        beat_last    = 1'b0;
        beat_cnt     = '0;
        beat_w       = comb_w[N-1:0];
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (!in_pass && total >= TW'(N)) begin
                        load         = 1'b1;
                        beat_cnt     = CW'(N);
                        stage_w_nx   = comb_w[2*N-2:N];
                        stage_cnt_nx = CW'(total - TW'(N));
                    end else if (!in_pass) begin
                        stage_w_nx   = comb_w[N-2:0];
                        stage_cnt_nx = CW'(total);
                    end else if (total <= TW'(N)) begin
                        load         = 1'b1;
                        beat_cnt     = CW'(total);
                        beat_last    = 1'b1;
                        stage_cnt_nx = '0;
                    end else begin
                        // Residue exceeds one beat: send a full beat now, drain the rest next
                        load         = 1'b1;
                        beat_cnt     = CW'(N);
                        stage_w_nx   = comb_w[2*N-2:N];
                        stage_cnt_nx = CW'(total - TW'(N));
                        state_nx     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    load         = 1'b1;
                    beat_w       = {{W{1'b0}}, stage_w};
                    beat_cnt     = stage_cnt;
                    beat_last    = 1'b1;
                    stage_cnt_nx = '0;
                    state_nx     = ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            stage_cnt  <= '0;
            out_vld_r  <= 1'b0;
            out_msk_r  <= '0;
            out_cnt_r  <= '0;
            out_last_r <= 1'b0;
        end else begin
            state     <= state_nx;
            stage_cnt <= stage_cnt_nx;
            if (out_free) begin
                out_vld_r <= load;
                if (load) begin
                    out_cnt_r  <= beat_cnt;
                    out_msk_r  <= ~({N{1'b1}} << beat_cnt);
                    out_last_r <= beat_last;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_w <= stage_w_nx;
        if (out_free && load) begin
            out_r <= beat_w;
        end
    end

    a_prefix: assert property (@(posedge clk) disable iff (rst)
        in_vld |-> ((in_vld_w & (in_vld_w + 1'b1)) == '0));
    a_stage: assert property (@(posedge clk) disable iff (rst)
        (state == ST_RUN) |-> (stage_cnt < CW'(N)));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_vld_r && !out_rdy) |=> (out_vld_r && $stable(out_r) && $stable(out_cnt_r)
                                     && $stable(out_msk_r) && $stable(out_last_r)));

endmodule

// File: tb/tb_pack_gather.sv
// Bench for pack_gather (N=4, W=8): word-queue reference model, per-cycle compare, directed literals.
module tb_pack_gather;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        logic [N*W-1:0] d;
        int             cnt;
        bit             last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_vld = 1'b0;
    logic                  in_rdy;
    logic                  in_pass = 1'b0;
    logic [N-1:0][W-1:0]   in_w = '0;
    logic [N-1:0]          in_vld_w = '0;
    logic                  out_vld_r;
    logic                  out_rdy = 1'b1;
    logic [N-1:0][W-1:0]   out_r;
    logic [N-1:0]          out_msk_r;
    logic [$clog2(N):0]    out_cnt_r;
    logic                  out_last_r;

    int    total = 0;
    int    bad = 0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];
    logic [W-1:0] held_q[$];

    pack_gather #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_pass    (in_pass),
        .in_w       (in_w),
        .in_vld_w   (in_vld_w),
        .out_vld_r  (out_vld_r),
        .out_rdy    (out_rdy),
        .out_r      (out_r),
        .out_msk_r  (out_msk_r),
        .out_cnt_r  (out_cnt_r),
        .out_last_r (out_last_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] keep_lanes(input logic [N*W-1:0] d, input int c);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (i < c) r[i*W +: W] = d[i*W +: W];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] lane_mask(input int c);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            if (i < c) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Reference: a FIFO of held words; full beats pop N, a pass pops everything.
    task automatic model_accept(input logic [N*W-1:0] w, input int k, input bit pass);
        beat_t b;
        for (int i = 0; i < k; i++) held_q.push_back(w[i*W +: W]);
        while (held_q.size() >= N && (!pass || held_q.size() > N)) begin
            b.d = '0;
            for (int i = 0; i < N; i++) b.d[i*W +: W] = held_q.pop_front();
            b.cnt  = N;
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        if (pass) begin
            b.d   = '0;
            b.cnt = held_q.size();
            for (int i = 0; i < b.cnt; i++) b.d[i*W +: W] = held_q.pop_front();
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [N*W-1:0] w, input int k, input bit pass);
        int guard;
        guard = 0;
        @(negedge clk);
        in_vld   = 1'b1;
        in_w     = w;
        in_vld_w = lane_mask(k);
        in_pass  = pass;
        #1;
        while (!in_rdy) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout in_rdy stuck low at %0t", $time);
                in_vld  = 1'b0;
                in_pass = 1'b0;
                return;
            end
        end
        model_accept(w, k, pass);
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_pass = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle compare against the model, plus the backpressure hold rule.
    logic            hold_prev = 1'b0;
    logic [N*W-1:0]  prev_r;
    logic [N-1:0]    prev_msk;
    logic [$clog2(N):0] prev_cnt;
    logic            prev_last;
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_vld", 64'(out_vld_r), 64'd1);
                check("hold_data", 64'(out_r), 64'(prev_r));
                check("hold_cnt", 64'(out_cnt_r), 64'(prev_cnt));
                check("hold_msk", 64'(out_msk_r), 64'(prev_msk));
                check("hold_last", 64'(out_last_r), 64'(prev_last));
            end
            if (out_vld_r) begin
                if (!out_rdy) begin
                    check("in_rdy_bp", 64'(in_rdy), 64'd0);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected got cnt=%0d exp none at %0t", out_cnt_r, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_cnt", 64'(out_cnt_r), 64'(e.cnt));
                    check("beat_last", 64'(out_last_r), 64'(e.last));
                    check("beat_msk", 64'(out_msk_r), 64'(lane_mask(e.cnt)));
                    check("beat_data", 64'(keep_lanes(out_r, e.cnt)), 64'(keep_lanes(e.d, e.cnt)));
                end
            end
            hold_prev = out_vld_r && !out_rdy;
            prev_r    = out_r;
            prev_cnt  = out_cnt_r;
            prev_msk  = out_msk_r;
            prev_last = out_last_r;
        end
    end

    initial begin
        logic [N*W-1:0] w;
        int k;
        bit pass;
        int guard;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_vld", 64'(out_vld_r), 64'd0);
        check("rst_cnt", 64'(out_cnt_r), 64'd0);
        check("rst_msk", 64'(out_msk_r), 64'd0);
        check("rst_last", 64'(out_last_r), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);

        // Two 3-word vectors, then a 1-word pass
        send(32'hEEA2A1A0, 3, 1'b0);
        @(negedge clk); #1;
        check("a_no_beat", 64'(out_vld_r), 64'd0);
        send(32'hEEB2B1B0, 3, 1'b0);
        @(negedge clk); #1;
        check("ab_vld", 64'(out_vld_r), 64'd1);
        check("ab_data", 64'(out_r), 64'h00000000B0A2A1A0);
        check("ab_cnt", 64'(out_cnt_r), 64'd4);
        check("ab_msk", 64'(out_msk_r), 64'b1111);
        check("ab_last", 64'(out_last_r), 64'd0);
        send(32'hEEEEEEC0, 1, 1'b1);
        @(negedge clk); #1;
        check("c_data", 64'(keep_lanes(out_r, 3)), 64'h0000000000C0B2B1);
        check("c_cnt", 64'(out_cnt_r), 64'd3);
        check("c_msk", 64'(out_msk_r), 64'b0111);
        check("c_last", 64'(out_last_r), 64'd1);

        // Zero-word vector without pass is a no-op
        send(32'hEEEEEEEE, 0, 1'b0);
        @(negedge clk); #1;
        check("k0_no_beat", 64'(out_vld_r), 64'd0);

        // Residue of 7 words under pass: full beat, one-cycle flush, 3-word last beat
        send(32'hEED2D1D0, 3, 1'b0);
        send(32'hE3E2E1E0, 4, 1'b1);
        @(negedge clk); #1;
        check("f1_data", 64'(out_r), 64'h00000000E0D2D1D0);
        check("f1_last", 64'(out_last_r), 64'd0);
        check("f1_in_rdy", 64'(in_rdy), 64'd0);
        @(negedge clk); #1;
        check("f2_data", 64'(keep_lanes(out_r, 3)), 64'h0000000000E3E2E1);
        check("f2_cnt", 64'(out_cnt_r), 64'd3);
        check("f2_last", 64'(out_last_r), 64'd1);
        check("f2_in_rdy", 64'(in_rdy), 64'd1);

        // Empty flush
        send(32'hEEEEEEEE, 0, 1'b1);
        @(negedge clk); #1;
        check("e_vld", 64'(out_vld_r), 64'd1);
        check("e_cnt", 64'(out_cnt_r), 64'd0);
        check("e_msk", 64'(out_msk_r), 64'd0);
        check("e_last", 64'(out_last_r), 64'd1);

        // Backpressure for 5 cycles
        @(negedge clk);
        out_rdy = 1'b0;
        send(32'hF3F2F1F0, 4, 1'b0);
        repeat (5) begin
            @(negedge clk); #1;
            check("bp_in_rdy", 64'(in_rdy), 64'd0);
            check("bp_vld", 64'(out_vld_r), 64'd1);
            check("bp_data", 64'(out_r), 64'h00000000F3F2F1F0);
            check("bp_cnt", 64'(out_cnt_r), 64'd4);
        end
        @(negedge clk);
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in_rdy), 64'd1);
        @(negedge clk); #1;
        check("bp_consumed", 64'(out_vld_r), 64'd0);

        // Reset while stuck in the flush state
        @(negedge clk);
        out_rdy = 1'b0;
        send(32'hEE626160, 3, 1'b0);
        send(32'h73727170, 4, 1'b1);
        @(negedge clk); #1;
        check("rf_in_rdy_blocked", 64'(in_rdy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        held_q.delete();
        @(negedge clk); #1;
        check("rf_vld", 64'(out_vld_r), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rf_in_rdy", 64'(in_rdy), 64'd1);
        out_rdy = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("rf_no_beat", 64'(out_vld_r), 64'd0);
        end
        send(32'hEEEEEE90, 1, 1'b1);
        @(negedge clk); #1;
        check("rf_after_cnt", 64'(out_cnt_r), 64'd1);
        check("rf_after_data", 64'(keep_lanes(out_r, 1)), 64'h90);
        check("rf_after_last", 64'(out_last_r), 64'd1);

        // Randomized traffic with random downstream stalls
        rand_rdy = 1'b1;
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int i = 0; i < N; i++) w[i*W +: W] = W'($urandom);
            k    = $urandom_range(0, N);
            pass = ($urandom_range(0, 4) == 0);
            send(w, k, pass);
        end
        send('0, 0, 1'b1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
